// File: rtl/inst_cache_pkg.sv
// Shared constants and address-field helpers for the direct-mapped instruction cache.
package inst_cache_pkg;

  localparam int unsigned DEFAULT_LINES = 64;
  localparam int unsigned LINE_W        = 128;
  localparam int unsigned WORDS         = 4;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned OFFSET_W      = 4;  // byte offset plus word select

  // Index width for a given line count.
  function automatic int unsigned index_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned lines);
    return 32 - $clog2(lines) - OFFSET_W;
  endfunction

  function automatic logic [1:0] field_word(input logic [31:0] addr);
    return addr[3:2];
  endfunction

  function automatic logic [31:0] field_index(input logic [31:0] addr, input int unsigned iw);
    logic [31:0] mask;
    mask = (32'd1 << iw) - 32'd1;
    return (addr >> OFFSET_W) & mask;
  endfunction

  function automatic logic [31:0] field_tag(input logic [31:0] addr, input int unsigned iw);
    return addr >> (iw + OFFSET_W);
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch/memory-facing signal bundle of the instruction cache.
interface inst_cache_if;
  import inst_cache_pkg::*;

  logic [31:0]       address;
  logic [LINE_W-1:0] data;
  logic [WORD_W-1:0] inst;
  logic              hit;

  modport master (output address, output data, input inst, input hit);
  modport slave  (input address, input data, output inst, output hit);

endinterface

// File: rtl/inst_cache_line_sel.sv
// Combinational 4:1 word mux over a 128-bit cache line; word 0 is the low 32 bits.
module inst_cache_line_sel
  import inst_cache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [1:0]        word,
  output logic [WORD_W-1:0] inst
);

  always_comb begin
    inst = '0;
    unique case (word)
      2'd0: inst = line[31:0];
      2'd1: inst = line[63:32];
      2'd2: inst = line[95:64];
      2'd3: inst = line[127:96];
      default: inst = '0;
    endcase
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational lookup, one-edge refill on miss.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINES = DEFAULT_LINES
) (
  input  logic        Clk,
  input  logic        Rst_n,
  inst_cache_if.slave bus
);

  localparam int unsigned IW = index_width(LINES);
  localparam int unsigned TW = tag_width(LINES);

  logic [LINES-1:0]  valid_q;
  logic [TW-1:0]     tag_q  [LINES];
  logic [LINE_W-1:0] line_q [LINES];

  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic [1:0]        word;
  logic [WORD_W-1:0] sel_word;
  logic              hit;

  always_comb begin
    idx  = IW'(field_index(bus.address, IW));
    tag  = TW'(field_tag(bus.address, IW));
    word = field_word(bus.address);
    hit  = valid_q[idx] && (tag_q[idx] == tag);
  end

  inst_cache_line_sel u_line_sel (
    .line (line_q[idx]),
    .word (word),
    .inst (sel_word)
  );

  assign bus.hit  = hit;
  assign bus.inst = hit ? sel_word : '0;

  // Only valid bits are reset; a cleared valid bit masks stale tag/data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= '0;
    end else if (!hit) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Rst_n gating keeps a refill from landing on an edge coincident with reset.
  always_ff @(posedge Clk) begin
    if (Rst_n && !hit) begin
      line_q[idx] <= bus.data;
      tag_q[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache with LINES=64.
module tb_inst_cache;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  inst_cache_if bus ();

  inst_cache #(.LINES(64)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  localparam logic [127:0] LINE_A = 128'h000000FFFFFFFFFFFFFFFFFF;
  localparam logic [127:0] LINE_B = 128'h44444444333333332222222211111111;
  localparam logic [127:0] LINE_C = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.address = 32'h0;
    bus.data = LINE_B;

    // Held reset: an edge with a missing address must not fill.
    @(posedge clk); #1;
    chk("rst_hit", 32'(bus.hit), 32'h0);
    chk("rst_inst", bus.inst, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_hit", 32'(bus.hit), 32'h0);
    chk("post_rst_inst", bus.inst, 32'h0);

    // Cold miss then fill.
    bus.address = 32'h0ABCA333;
    bus.data = LINE_A;
    #1;
    chk("cold_hit", 32'(bus.hit), 32'h0);
    chk("cold_inst", bus.inst, 32'h0);
    @(posedge clk); #1;
    chk("fillA_hit", 32'(bus.hit), 32'h1);
    chk("fillA_inst", bus.inst, 32'hFFFFFFFF);

    // Different line, index 20.
    @(negedge clk);
    bus.address = 32'd1345;
    bus.data = LINE_B;
    #1;
    chk("B_miss_hit", 32'(bus.hit), 32'h0);
    @(posedge clk); #1;
    bus.data = 128'h0;  // data must be ignored outside the refill edge
    chk("fillB_hit", 32'(bus.hit), 32'h1);
    chk("fillB_inst", bus.inst, 32'h11111111);

    // Return to A and walk the words, all inside one low phase.
    @(negedge clk);
    bus.address = 32'h0ABCA333; #1;
    chk("A_again_hit", 32'(bus.hit), 32'h1);
    chk("A_again_inst", bus.inst, 32'hFFFFFFFF);
    bus.address = 32'h0ABCA33C; #1;
    chk("A_w3", bus.inst, 32'h00000000);
    chk("A_w3_hit", 32'(bus.hit), 32'h1);
    bus.address = 32'h0ABCA338; #1;
    chk("A_w2", bus.inst, 32'h000000FF);
    bus.address = 32'd1349; #1;
    chk("B_w1", bus.inst, 32'h22222222);
    bus.address = 32'd1356; #1;
    chk("B_w3", bus.inst, 32'h44444444);

    // Conflict: same index 0x33, new tag.
    bus.address = 32'h1ABCA333;
    bus.data = LINE_C;
    #1;
    chk("C_miss_hit", 32'(bus.hit), 32'h0);
    @(posedge clk); #1;
    chk("fillC_hit", 32'(bus.hit), 32'h1);
    chk("fillC_inst", bus.inst, 32'h89ABCDEF);
    @(negedge clk);
    bus.address = 32'h1ABCA33C; #1;
    chk("C_w3", bus.inst, 32'hDEADBEEF);
    bus.address = 32'h0ABCA333; #1;
    chk("A_evicted_hit", 32'(bus.hit), 32'h0);
    chk("A_evicted_inst", bus.inst, 32'h0);

    // Async reset between edges drops hit without a clock.
    bus.address = 32'd1345; #1;
    chk("B_pre_rst_hit", 32'(bus.hit), 32'h1);
    rst_n = 1'b0; #1;
    chk("async_rst_hit", 32'(bus.hit), 32'h0);
    chk("async_rst_inst", bus.inst, 32'h0);
    bus.data = LINE_B;
    @(posedge clk); #1;
    chk("rst_edge_nofill", 32'(bus.hit), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("release_hit", 32'(bus.hit), 32'h0);
    @(posedge clk); #1;
    chk("refill_after_rst_hit", 32'(bus.hit), 32'h1);
    chk("refill_after_rst_inst", bus.inst, 32'h11111111);
    @(negedge clk);
    bus.address = 32'h1ABCA333; #1;
    chk("C_cleared_hit", 32'(bus.hit), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
